// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA/CEA raster timing generator with pixel enable and output delay
//
// Purpose: walks an (h, v) raster of H_TOTAL x V_TOTAL pixels, advancing one
// pixel per clk_i edge with ce_i=1, and derives sync, display-enable and
// line/frame strobes. The flags can be delayed by PIPE_DELAY pixels so they
// line up with a downstream pixel pipeline; x_o/y_o are never delayed.
//
// Ports:
//   clk_i         system clock
//   rst_ni        synchronous active-low reset (wins over ce_i)
//   ce_i          pixel enable; nothing advances while low
//   x_o, y_o      current raster position, undelayed
//   hsync_o       horizontal sync at polarity HSYNC_POL, delayed
//   vsync_o       vertical sync at polarity VSYNC_POL, delayed
//   de_o          display enable, active-high, delayed
//   line_start_o  one-pixel strobe at h==0, delayed
//   frame_start_o one-pixel strobe at h==0, v==0, delayed
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int CNT_W      = 10,
  parameter int PIPE_DELAY = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ce_i,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o,
  output logic             line_start_o,
  output logic             frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Boundaries are compared one bit wider than the counters so a sync end
  // that lands exactly on 2^CNT_W does not wrap to zero.
  localparam logic [CNT_W:0] H_DE_END = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] H_HS_BEG = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] H_HS_END = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] V_DE_END = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] V_VS_BEG = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] V_VS_END = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  localparam logic HS_POL = (HSYNC_POL != 0);
  localparam logic VS_POL = (VSYNC_POL != 0);

  generate
    if (H_SYNC < 1 || V_SYNC < 1 || H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_widths
      $error("vga_timing_gen: H_SYNC, V_SYNC, H_ACTIVE and V_ACTIVE must be >= 1");
    end
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_cnt_w
      $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_bad_delay
      $error("vga_timing_gen: PIPE_DELAY must be 0..15");
    end
  endgenerate

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (ce_i) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Raw flags are kept active-high internally; polarity is applied only at
  // the outputs so an all-zero (flushed) delay line means "everything idle".
  logic [CNT_W:0] h_ext, v_ext;
  logic [4:0]     raw_flags;   // {fs, ls, de, vs, hs}
  logic [4:0]     dly_flags;

  assign h_ext = {1'b0, h_q};
  assign v_ext = {1'b0, v_q};

  assign raw_flags[0] = (h_ext >= H_HS_BEG) && (h_ext < H_HS_END);
  assign raw_flags[1] = (v_ext >= V_VS_BEG) && (v_ext < V_VS_END);
  assign raw_flags[2] = (h_ext < H_DE_END) && (v_ext < V_DE_END);
  assign raw_flags[3] = (h_q == '0);
  assign raw_flags[4] = (h_q == '0) && (v_q == '0);

  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign dly_flags = raw_flags;
    end else begin : g_delay
      logic [4:0] pipe_q [PIPE_DELAY];

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          for (int i = 0; i < PIPE_DELAY; i++) begin
            pipe_q[i] <= '0;
          end
        end else if (ce_i) begin
          pipe_q[0] <= raw_flags;
          for (int i = 1; i < PIPE_DELAY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
          end
        end
      end

      assign dly_flags = pipe_q[PIPE_DELAY-1];
    end
  endgenerate

  assign x_o           = h_q;
  assign y_o           = v_q;
  assign hsync_o       = dly_flags[0] ^ ~HS_POL;
  assign vsync_o       = dly_flags[1] ^ ~VS_POL;
  assign de_o          = dly_flags[2];
  assign line_start_o  = dly_flags[3];
  assign frame_start_o = dly_flags[4];

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA controller.
- Generates horizontal/vertical counters, sync pulses, display-enable, line-start and frame-start strobes for any CEA/VESA-style mode.
- Adds a pixel clock-enable, so it can run from a faster system clock (e.g. 100 MHz with 1-in-4 enable).
- Adds a configurable output delay, so sync/DE line up with a downstream pixel pipeline; x/y run ahead of the delayed flags by exactly that many pixels.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync_o (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync_o
- CNT_W, 10, counter/coordinate width; requires H_TOTAL and V_TOTAL to be at most 2^CNT_W
- PIPE_DELAY, 0, pixel-enable cycles of delay on hsync/vsync/de/strobes (0..15)

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset, synchronous and active-low
- ce_i  in  1  pixel enable; all state advances only on cycles with ce_i=1
- x_o  out  CNT_W  current horizontal count (0..H_TOTAL-1), undelayed
- y_o  out  CNT_W  current vertical count (0..V_TOTAL-1), undelayed
- hsync_o  out  1  horizontal sync, polarity HSYNC_POL, delayed
- vsync_o  out  1  vertical sync, polarity VSYNC_POL, delayed
- de_o  out  1  display enable (active-high), delayed
- line_start_o  out  1  1-ce pulse at h==0, delayed
- frame_start_o  out  1  1-ce pulse at h==0 and v==0, delayed

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Line order is active, front porch, sync, back porch.
- Reset (rst_ni=0 at a clk_i edge, regardless of ce_i):
  - h, v = 0.
  - Delay line flushed to inactive: de=0, strobes=0, syncs at their deasserted level (~POL).
  - Outputs: x_o=0, y_o=0, de_o=0, line_start_o=0, frame_start_o=0, hsync_o=~HSYNC_POL, vsync_o=~VSYNC_POL.
- Counters, on each clk_i edge with ce_i=1 and out of reset:
  - If h==H_TOTAL-1: h<=0; then v<=0 if v==V_TOTAL-1, else v<=v+1.
  - Otherwise h<=h+1.
  - With ce_i=0, all registers hold.
- Raw flags are combinational from (h, v):
  - hs_raw = (h >= H_ACTIVE+H_FP) && (h < H_ACTIVE+H_FP+H_SYNC)
  - vs_raw = (v >= V_ACTIVE+V_FP) && (v < V_ACTIVE+V_FP+V_SYNC); applies for entire lines.
  - de_raw = (h < H_ACTIVE) && (v < V_ACTIVE)
  - ls_raw = (h==0); fs_raw = (h==0 && v==0)
- Delay line:
  - Flags pass through a PIPE_DELAY-deep shift register that shifts only on ce_i=1.
  - Each output = delayed raw flag XOR-mapped to its polarity.
  - PIPE_DELAY=0: outputs are combinational from the counter registers (no extra register).
  - In general, the flags shown with x_o=N describe pixel N-PIPE_DELAY (mod H_TOTAL, carrying into v).
- Strobes are high for exactly one ce-qualified pixel. When ce_i is low they may remain high for those clk_i cycles, because the registers hold.
- Reset mid-frame: takes effect on the next clk_i edge. After release, the first ce pixel is (0,0) with fs_raw=1. With PIPE_DELAY>0, frame_start_o appears PIPE_DELAY ce-cycles later.
- Counters never exceed TOTAL-1. No saturation or overflow paths exist given the CNT_W constraint.
- Compile-time check: H_SYNC, V_SYNC, H_ACTIVE and V_ACTIVE must each be at least 1; otherwise elaboration $error.

Test Plan:
- Defaults, PIPE_DELAY=0, ce_i tied 1, release reset → x_o counts 0..799 and wraps; hsync_o low exactly for x_o 656..751 (96 cycles); de_o high for x_o 0..639 on y_o<480.
- Run a full frame → vsync_o low for y_o 490..491 across all 1600 pixels; frame_start_o single pulse at (0,0); 525 line_start_o pulses per frame; (799,524)→(0,0) wrap.
- ce_i pulsed 1-in-4 → counters and outputs change only after ce cycles; one line takes 3200 clk_i cycles; hsync_o low for 384 clk_i cycles.
- PIPE_DELAY=3 → de_o rises when x_o==3, y_o==0; hsync_o falls when x_o==659; frame_start_o is high when (x_o,y_o)==(3,0).
- Small mode: H=8/2/3/3, V=4/1/2/1, HSYNC_POL=VSYNC_POL=1 → H_TOTAL=16, hsync_o high for h 10..12; V_TOTAL=8, vsync_o high for v 5..6; de_o high 8 of 16 pixels on lines 0..3.
- Assert rst_ni=0 for 1 cycle at (400,300) with PIPE_DELAY=2 → next cycle x_o=y_o=0, de_o=0, syncs deasserted; after release, de_o rises at x_o==2.
